// File: rtl/r_backward_fabric_if.sv
// rtl/r_backward_fabric_if.sv - valid/ready beat stream interface for r_backward_fabric
interface r_backward_fabric_if #(
  parameter int WIDTH = 14
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/r_backward_fabric.sv
// rtl/r_backward_fabric.sv - 1-to-2 beat router with registered outputs
// Optional input skid entry enabled by defining RBF_SKID_EN.
module r_backward_fabric #(
  parameter int WIDTH   = 14,
  parameter int SEL_BIT = 13
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  r_backward_fabric_if.slave    up,
  r_backward_fabric_if.master   port0,
  r_backward_fabric_if.master   port1
);

  logic [WIDTH-1:0] data0_q;
  logic [WIDTH-1:0] data1_q;
  logic             full0_q;
  logic             full1_q;
  logic             avail0;
  logic             avail1;
  logic             load0;
  logic             load1;
  logic [WIDTH-1:0] load_data;

  // A register can take a beat when empty or when its current beat drains now.
  assign avail0 = !full0_q || port0.ready;
  assign avail1 = !full1_q || port1.ready;

  assign port0.data  = data0_q;
  assign port0.valid = full0_q;
  assign port1.data  = data1_q;
  assign port1.valid = full1_q;

`ifdef RBF_SKID_EN
  logic             skid_full_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_sel;
  logic             in_sel;
  logic             in_avail;
  logic             skid_drain;
  logic             in_direct;
  logic             in_to_skid;

  assign skid_sel   = skid_data_q[SEL_BIT];
  assign in_sel     = up.data[SEL_BIT];
  assign in_avail   = in_sel ? avail1 : avail0;
  assign skid_drain = skid_full_q && (skid_sel ? avail1 : avail0);
  // New input is only taken while the skid is empty, so the two sources never collide.
  assign in_direct  = !skid_full_q && up.valid && in_avail;
  assign in_to_skid = !skid_full_q && up.valid && !in_avail;
  assign load_data  = skid_full_q ? skid_data_q : up.data;
  assign load0      = (skid_drain && !skid_sel) || (in_direct && !in_sel);
  assign load1      = (skid_drain && skid_sel)  || (in_direct && in_sel);
  assign up.ready   = !skid_full_q;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
    end else if (skid_drain) begin
      skid_full_q <= 1'b0;
    end else if (in_to_skid) begin
      skid_full_q <= 1'b1;
      skid_data_q <= up.data;
    end
  end
`else
  logic in_sel;
  logic in_avail;
  logic accept;

  assign in_sel    = up.data[SEL_BIT];
  assign in_avail  = in_sel ? avail1 : avail0;
  assign up.ready  = in_avail;
  assign accept    = up.valid && in_avail;
  assign load_data = up.data;
  assign load0     = accept && !in_sel;
  assign load1     = accept && in_sel;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      full0_q <= 1'b0;
      data0_q <= '0;
    end else if (load0) begin
      full0_q <= 1'b1;
      data0_q <= load_data;
    end else if (port0.ready) begin
      full0_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      full1_q <= 1'b0;
      data1_q <= '0;
    end else if (load1) begin
      full1_q <= 1'b1;
      data1_q <= load_data;
    end else if (port1.ready) begin
      full1_q <= 1'b0;
    end
  end

endmodule
